// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port block-memory arbiter: FSM states, owner
// encoding and default bus widths.
package memory_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF  = 28;
    localparam int BLOCK_WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    function automatic owner_e other_side(input owner_e o);
        return (o == OWN_INST) ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and memory-side block handshakes of the arbiter; the arbiter
// uses the slave view, caches and memory (or a bench) the master view.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF
);
    logic                   INST_MEM_READ;
    logic [ADDR_WIDTH-1:0]  INST_MEM_ADDRESS;
    logic [BLOCK_WIDTH-1:0] INST_MEM_READDATA;
    logic                   INST_MEM_BUSYWAIT;

    logic                   DATA_MEM_READ;
    logic                   DATA_MEM_WRITE;
    logic [ADDR_WIDTH-1:0]  DATA_MEM_ADDRESS;
    logic [BLOCK_WIDTH-1:0] DATA_MEM_WRITEDATA;
    logic [BLOCK_WIDTH-1:0] DATA_MEM_READDATA;
    logic                   DATA_MEM_BUSYWAIT;

    logic                   MEM_READ;
    logic                   MEM_WRITE;
    logic [ADDR_WIDTH-1:0]  MEM_ADDRESS;
    logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA;
    logic [BLOCK_WIDTH-1:0] MEM_READDATA;
    logic                   MEM_BUSYWAIT;

    modport slave (
        input  INST_MEM_READ, INST_MEM_ADDRESS,
        output INST_MEM_READDATA, INST_MEM_BUSYWAIT,
        input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDRESS, DATA_MEM_WRITEDATA,
        output DATA_MEM_READDATA, DATA_MEM_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport master (
        output INST_MEM_READ, INST_MEM_ADDRESS,
        input  INST_MEM_READDATA, INST_MEM_BUSYWAIT,
        output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDRESS, DATA_MEM_WRITEDATA,
        input  DATA_MEM_READDATA, DATA_MEM_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );

endinterface

// File: rtl/memory_arbiter_rr.sv
// Combinational two-way round-robin grant: a lone requester wins outright,
// a tie goes to the side that was not served last.
module memory_arbiter_rr
    import memory_arbiter_pkg::*;
(
    input  logic   req_inst_i,
    input  logic   req_data_i,
    input  owner_e last_i,
    output logic   gnt_vld_o,
    output owner_e gnt_owner_o
);

    always_comb begin
        gnt_vld_o   = req_inst_i | req_data_i;
        gnt_owner_o = OWN_INST;
        if (req_inst_i && req_data_i) begin
            gnt_owner_o = other_side(last_i);
        end else if (req_data_i) begin
            gnt_owner_o = OWN_DATA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction-cache reads and data-cache reads/write-backs onto one
// unified block memory, giving each cache its usual busywait handshake.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF
)(
    input  logic             CLK,
    input  logic             RESET,
    memory_arbiter_if.slave  bus
);

    arb_state_e             state_q;
    owner_e                 owner_q;
    owner_e                 last_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [BLOCK_WIDTH-1:0] mem_wdata_q;
    logic [BLOCK_WIDTH-1:0] inst_rdata_q;
    logic [BLOCK_WIDTH-1:0] data_rdata_q;

    logic   inst_req;
    logic   data_req;
    logic   gnt_vld_d;
    owner_e gnt_owner_d;
    logic   release_inst;
    logic   release_data;

    assign inst_req = bus.INST_MEM_READ;
    assign data_req = bus.DATA_MEM_READ | bus.DATA_MEM_WRITE;

    memory_arbiter_rr u_rr (
        .req_inst_i  (inst_req),
        .req_data_i  (data_req),
        .last_i      (last_q),
        .gnt_vld_o   (gnt_vld_d),
        .gnt_owner_o (gnt_owner_d)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            last_q       <= OWN_INST;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld_d) begin
                        owner_q <= gnt_owner_d;
                        state_q <= ST_ISSUE;
                        if (gnt_owner_d == OWN_DATA) begin
                            // A simultaneous read and write from the data side is a write.
                            mem_addr_q  <= bus.DATA_MEM_ADDRESS;
                            mem_wdata_q <= bus.DATA_MEM_WRITEDATA;
                            mem_write_q <= bus.DATA_MEM_WRITE;
                            mem_read_q  <= ~bus.DATA_MEM_WRITE;
                        end else begin
                            mem_addr_q  <= bus.INST_MEM_ADDRESS;
                            mem_write_q <= 1'b0;
                            mem_read_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (!bus.MEM_BUSYWAIT) begin
                        if (mem_read_q) begin
                            if (owner_q == OWN_DATA) data_rdata_q <= bus.MEM_READDATA;
                            else                     inst_rdata_q <= bus.MEM_READDATA;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        last_q      <= owner_q;
                        state_q     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Busywait is combinational so a cache stalls in the very cycle it requests.
    assign release_inst = (state_q == ST_RELEASE) && (owner_q == OWN_INST);
    assign release_data = (state_q == ST_RELEASE) && (owner_q == OWN_DATA);

    assign bus.INST_MEM_BUSYWAIT = inst_req & ~release_inst;
    assign bus.DATA_MEM_BUSYWAIT = data_req & ~release_data;
    assign bus.INST_MEM_READDATA = inst_rdata_q;
    assign bus.DATA_MEM_READDATA = data_rdata_q;
    assign bus.MEM_READ          = mem_read_q;
    assign bus.MEM_WRITE         = mem_write_q;
    assign bus.MEM_ADDRESS       = mem_addr_q;
    assign bus.MEM_WRITEDATA     = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small unified-memory model that
// stays busy MEM_B cycles after it first registers a strobe.
module tb_memory_arbiter;

    localparam int MEM_B = 5;

    logic clk;
    logic rst;

    memory_arbiter_if #(.ADDR_WIDTH(28), .BLOCK_WIDTH(128)) bus ();

    memory_arbiter #(.ADDR_WIDTH(28), .BLOCK_WIDTH(128)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rd_of(input logic [27:0] a);
        if (a == 28'h4) return {16{8'hA5}};
        return {4{32'hCAFE_0000 ^ {4'h0, a}}};
    endfunction

    // Memory model
    logic        mbusy = 1'b0;
    logic        mact  = 1'b0;
    logic        mdone = 1'b0;
    int          mcnt  = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [27:0] acc_q[$];

    assign bus.MEM_BUSYWAIT = mbusy;
    assign bus.MEM_READDATA = rd_of(bus.MEM_ADDRESS);

    always @(posedge clk) begin
        if (rst) begin
            mbusy <= 1'b0; mact <= 1'b0; mdone <= 1'b0; mcnt <= 0;
        end else if (!(bus.MEM_READ || bus.MEM_WRITE)) begin
            mbusy <= 1'b0; mact <= 1'b0; mdone <= 1'b0;
        end else begin
            if (bus.MEM_READ)  rd_cnt <= rd_cnt + 1;
            if (bus.MEM_WRITE) wr_cnt <= wr_cnt + 1;
            if (!mact) begin
                mact  <= 1'b1;
                mbusy <= 1'b1;
                mcnt  <= MEM_B;
                acc_q.push_back(bus.MEM_ADDRESS);
            end else if (!mdone) begin
                if (mcnt == 1) begin
                    mbusy <= 1'b0;
                    mdone <= 1'b1;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_low(input bit side_data, input int limit, output int n);
        logic bw;
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cycle();
            bw = side_data ? bus.DATA_MEM_BUSYWAIT : bus.INST_MEM_BUSYWAIT;
            if (bw == 1'b0) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d_rel, i_rel, rel, base, rd0, wr0;
        bit i_early;
        logic [127:0] d_rd, i_rd;
        logic [127:0] wdat;

        rst = 1'b1;
        bus.INST_MEM_READ = 1'b0; bus.INST_MEM_ADDRESS = '0;
        bus.DATA_MEM_READ = 1'b0; bus.DATA_MEM_WRITE = 1'b0;
        bus.DATA_MEM_ADDRESS = '0; bus.DATA_MEM_WRITEDATA = '0;

        // Reset: busywait follows the request, then idle reset values
        cycle();
        bus.INST_MEM_READ = 1'b1;
        #1;
        check_val("rst_inst_bw_follows", bus.INST_MEM_BUSYWAIT, 1);
        check_val("rst_data_bw_follows", bus.DATA_MEM_BUSYWAIT, 0);
        cycle();
        bus.INST_MEM_READ = 1'b0;
        rst = 1'b0;
        cycle();
        check_val("rst_mem_read",   bus.MEM_READ, 0);
        check_val("rst_mem_write",  bus.MEM_WRITE, 0);
        check_val("rst_mem_addr",   bus.MEM_ADDRESS, 0);
        check_val("rst_mem_wdata",  bus.MEM_WRITEDATA, 0);
        check_val("rst_inst_rdata", bus.INST_MEM_READDATA, 0);
        check_val("rst_data_rdata", bus.DATA_MEM_READDATA, 0);

        // Single instruction read
        wr0 = wr_cnt;
        bus.INST_MEM_READ = 1'b1; bus.INST_MEM_ADDRESS = 28'h4;
        #1;
        check_val("t1_bw_same_cycle", bus.INST_MEM_BUSYWAIT, 1);
        cycle();
        check_val("t1_issue_read", bus.MEM_READ, 1);
        check_val("t1_issue_addr", bus.MEM_ADDRESS, 28'h4);
        wait_low(1'b0, 30, n);
        check_val("t1_release_cycle", n + 1, MEM_B + 3);
        check_val("t1_rdata", bus.INST_MEM_READDATA, {16{8'hA5}});
        cycle();
        check_val("t1_bw_high_after", bus.INST_MEM_BUSYWAIT, 1);
        bus.INST_MEM_READ = 1'b0;
        check_val("t1_no_write", wr_cnt - wr0, 0);
        cycle(); cycle();

        // Data write-back
        wdat = 128'h1234_5678_1234_5678_1234_5678_1234_5678;
        bus.DATA_MEM_WRITE = 1'b1; bus.DATA_MEM_ADDRESS = 28'h10; bus.DATA_MEM_WRITEDATA = wdat;
        #1;
        check_val("t2_bw_same_cycle", bus.DATA_MEM_BUSYWAIT, 1);
        cycle();
        check_val("t2_issue_write", bus.MEM_WRITE, 1);
        check_val("t2_issue_read",  bus.MEM_READ, 0);
        check_val("t2_issue_addr",  bus.MEM_ADDRESS, 28'h10);
        check_val("t2_issue_wdata", bus.MEM_WRITEDATA, wdat);
        cycle(); cycle();
        check_val("t2_wait_write_held", bus.MEM_WRITE, 1);
        wait_low(1'b1, 30, n);
        check_val("t2_release_cycle", n + 3, MEM_B + 3);
        check_val("t2_rdata_unchanged", bus.DATA_MEM_READDATA, 0);
        check_val("t2_write_dropped", bus.MEM_WRITE, 0);
        bus.DATA_MEM_WRITE = 1'b0;
        cycle(); cycle();

        // Simultaneous reads right after reset: data first, then inst
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        base = acc_q.size();
        bus.DATA_MEM_READ = 1'b1; bus.DATA_MEM_ADDRESS = 28'h20;
        bus.INST_MEM_READ = 1'b1; bus.INST_MEM_ADDRESS = 28'h30;
        d_rel = -1; i_rel = -1; i_early = 1'b0; d_rd = '0; i_rd = '0;
        for (int k = 1; k <= 60 && i_rel < 0; k++) begin
            cycle();
            if (d_rel < 0) begin
                if (!bus.INST_MEM_BUSYWAIT) i_early = 1'b1;
                if (!bus.DATA_MEM_BUSYWAIT) begin
                    d_rel = k; d_rd = bus.DATA_MEM_READDATA; bus.DATA_MEM_READ = 1'b0;
                end
            end else if (!bus.INST_MEM_BUSYWAIT) begin
                i_rel = k; i_rd = bus.INST_MEM_READDATA; bus.INST_MEM_READ = 1'b0;
            end
        end
        bus.DATA_MEM_READ = 1'b0; bus.INST_MEM_READ = 1'b0;
        check_val("t3_inst_held_during_data", i_early, 0);
        check_val("t3_data_release", d_rel, MEM_B + 3);
        check_val("t3_inst_release", i_rel, 8 + 1 + MEM_B + 3);
        check_val("t3_data_rdata", d_rd, rd_of(28'h20));
        check_val("t3_inst_rdata", i_rd, rd_of(28'h30));
        check_val("t3_order_first",  acc_q[base],     28'h20);
        check_val("t3_order_second", acc_q[base + 1], 28'h30);
        cycle(); cycle();

        // Both held for six accesses: D,I,D,I,D,I
        base = acc_q.size();
        rel = 0;
        bus.DATA_MEM_READ = 1'b1; bus.DATA_MEM_ADDRESS = 28'h60;
        bus.INST_MEM_READ = 1'b1; bus.INST_MEM_ADDRESS = 28'h70;
        for (int k = 0; k < 120 && rel < 6; k++) begin
            cycle();
            if (!bus.INST_MEM_BUSYWAIT || !bus.DATA_MEM_BUSYWAIT) rel++;
        end
        bus.DATA_MEM_READ = 1'b0; bus.INST_MEM_READ = 1'b0;
        check_val("t4_releases", rel, 6);
        check_val("t4_accesses", acc_q.size() - base, 6);
        for (int j = 0; j < 6; j++) begin
            check_val($sformatf("t4_grant%0d", j), acc_q[base + j], (j % 2 == 0) ? 28'h60 : 28'h70);
        end
        cycle(); cycle();

        // Reset in the third WAIT cycle, request held through it
        bus.DATA_MEM_READ = 1'b1; bus.DATA_MEM_ADDRESS = 28'h40;
        cycle(); cycle(); cycle(); cycle();
        check_val("t5_in_wait_read", bus.MEM_READ, 1);
        rst = 1'b1;
        cycle();
        check_val("t5_rst_mem_read",   bus.MEM_READ, 0);
        check_val("t5_rst_mem_write",  bus.MEM_WRITE, 0);
        check_val("t5_rst_data_rdata", bus.DATA_MEM_READDATA, 0);
        check_val("t5_rst_inst_rdata", bus.INST_MEM_READDATA, 0);
        check_val("t5_rst_bw_follows", bus.DATA_MEM_BUSYWAIT, 1);
        rst = 1'b0;
        wait_low(1'b1, 30, n);
        check_val("t5_regrant_release", n, MEM_B + 3);
        check_val("t5_rdata", bus.DATA_MEM_READDATA, rd_of(28'h40));
        bus.DATA_MEM_READ = 1'b0;
        cycle(); cycle();

        // Read and write together: write only
        rd0 = rd_cnt; wr0 = wr_cnt;
        wdat = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        bus.DATA_MEM_READ = 1'b1; bus.DATA_MEM_WRITE = 1'b1;
        bus.DATA_MEM_ADDRESS = 28'h50; bus.DATA_MEM_WRITEDATA = wdat;
        cycle();
        check_val("t6_issue_write", bus.MEM_WRITE, 1);
        check_val("t6_issue_read",  bus.MEM_READ, 0);
        wait_low(1'b1, 30, n);
        check_val("t6_release", n + 1, MEM_B + 3);
        check_val("t6_rdata_unchanged", bus.DATA_MEM_READDATA, rd_of(28'h40));
        check_val("t6_no_mem_read", rd_cnt - rd0, 0);
        check_val("t6_mem_wrote", (wr_cnt > wr0) ? 1 : 0, 1);
        bus.DATA_MEM_READ = 1'b0; bus.DATA_MEM_WRITE = 1'b0;
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
